// File: rtl/dct_stream_mac.sv
// dct_stream_mac: streaming DCT-II stage between the log-FBE stage and the lifter.
// Accepts one frame of up to N_IN signed samples and emits N_OUT saturated cepstral
// coefficients. Each accepted sample is multiplied against N_OUT coefficients through
// a pipelined MAC, one coefficient per cycle.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_data/in_valid/in_last/in_ready      sample input stream (k = 0..N_IN-1)
//   out_data/out_idx/out_valid/out_last/out_ready  coefficient output stream (j = 0..N_OUT-1)
//   frame_err      one-cycle pulse when the frame length differs from N_IN
// The coefficient table is supplied through COEF_ROM, word a = k*N_OUT + j at bits [a*COEF_W +: COEF_W].
module dct_stream_mac #(
    parameter int unsigned N_IN       = 26,
    parameter int unsigned N_OUT      = 13,
    parameter int unsigned IN_W       = 16,
    parameter int unsigned COEF_W     = 16,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned ACC_W      = 27,
    parameter int unsigned PROD_SHIFT = 10,
    parameter int unsigned OUT_SHIFT  = 5,
    parameter int unsigned MUL_LAT    = 3,
    parameter logic [N_IN*N_OUT*COEF_W-1:0] COEF_ROM = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic [4:0]              out_idx,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    frame_err
);

    localparam int unsigned K_W = $clog2(N_IN + 1);
    localparam int unsigned J_W = $clog2(N_OUT + 1);
    localparam int unsigned A_W = $clog2(N_IN * N_OUT);
    localparam int unsigned D_W = $clog2(MUL_LAT + 2);
    localparam int unsigned P_W = IN_W + COEF_W;
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic [1:0] {ACCEPT, MAC, DRAIN, OUTPUT} state_t;

    state_t                    state;
    logic [K_W-1:0]            k;
    logic [K_W-1:0]            k_cur;
    logic [K_W-1:0]            k_inc;
    logic                      k_full;
    logic signed [IN_W-1:0]    x_reg;
    logic [J_W-1:0]            mj;
    logic [J_W-1:0]            oj;
    logic [J_W-1:0]            oj_nxt;
    logic [D_W-1:0]            dcnt;
    logic                      end_q;
    logic                      err_q;
    logic                      acc_clr;
    logic [A_W-1:0]            rom_addr;

    logic signed [COEF_W-1:0]  rom [N_IN*N_OUT];
    logic                      s1_v;
    logic [J_W-1:0]            s1_j;
    logic signed [IN_W-1:0]    s1_x;
    logic signed [COEF_W-1:0]  s1_c;
    logic                      pv [MUL_LAT];
    logic [J_W-1:0]            pj [MUL_LAT];
    logic signed [P_W-1:0]     pp [MUL_LAT];
    logic signed [ACC_W-1:0]   prod_sh;
    logic signed [ACC_W-1:0]   acc [N_OUT];

    // Unpack the flat coefficient image into addressable words.
    for (genvar a = 0; a < N_IN * N_OUT; a++) begin : g_rom
        assign rom[a] = COEF_ROM[a*COEF_W +: COEF_W];
    end

    // Saturate the scaled accumulator to the output width.
    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> OUT_SHIFT;
        if (s > OUT_MAX) return OUT_W'(OUT_MAX);
        if (s < OUT_MIN) return OUT_W'(OUT_MIN);
        return OUT_W'(s);
    endfunction

    always_comb begin
        k_inc    = k + K_W'(1);
        k_full   = (k_inc == K_W'(N_IN));
        oj_nxt   = oj + J_W'(1);
        rom_addr = A_W'(k_cur) * A_W'(N_OUT) + A_W'(mj);
        acc_clr  = (state == ACCEPT) && in_valid && in_ready && (k == '0);
        prod_sh  = ACC_W'(pp[MUL_LAT-1] >>> PROD_SHIFT);
    end

    // Control FSM: sample intake, MAC issue, pipeline drain, coefficient output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCEPT;
            k         <= '0;
            k_cur     <= '0;
            x_reg     <= '0;
            mj        <= '0;
            oj        <= '0;
            dcnt      <= '0;
            end_q     <= 1'b0;
            err_q     <= 1'b0;
            in_ready  <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                ACCEPT: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        x_reg    <= in_data;
                        k_cur    <= k;
                        k        <= k_inc;
                        mj       <= '0;
                        end_q    <= in_last || k_full;
                        // Error when the frame ends early or fills up without in_last.
                        err_q    <= in_last ^ k_full;
                        in_ready <= 1'b0;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    if (mj == J_W'(N_OUT - 1)) begin
                        if (end_q) begin
                            dcnt  <= '0;
                            state <= DRAIN;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= ACCEPT;
                        end
                    end else begin
                        mj <= mj + J_W'(1);
                    end
                end
                DRAIN: begin
                    dcnt <= dcnt + D_W'(1);
                    if (dcnt == '0) frame_err <= err_q;
                    if (dcnt == D_W'(MUL_LAT + 1)) begin
                        oj    <= '0;
                        state <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= sat_out(acc[oj]);
                        out_idx   <= 5'(oj);
                        out_last  <= (oj == J_W'(N_OUT - 1));
                    end else if (out_ready) begin
                        if (oj == J_W'(N_OUT - 1)) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            k         <= '0;
                            in_ready  <= 1'b1;
                            state     <= ACCEPT;
                        end else begin
                            oj       <= oj_nxt;
                            out_data <= sat_out(acc[oj_nxt]);
                            out_idx  <= 5'(oj_nxt);
                            out_last <= (oj_nxt == J_W'(N_OUT - 1));
                        end
                    end
                end
                default: state <= ACCEPT;
            endcase
        end
    end

    // Pipeline valids and accumulators; a reset drops any in-flight products.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
            for (int i = 0; i < int'(MUL_LAT); i++) pv[i] <= 1'b0;
            for (int j = 0; j < int'(N_OUT); j++) acc[j] <= '0;
        end else begin
            s1_v  <= (state == MAC);
            pv[0] <= s1_v;
            for (int i = 1; i < int'(MUL_LAT); i++) pv[i] <= pv[i-1];
            if (acc_clr) begin
                for (int j = 0; j < int'(N_OUT); j++) acc[j] <= '0;
            end else if (pv[MUL_LAT-1]) begin
                acc[pj[MUL_LAT-1]] <= acc[pj[MUL_LAT-1]] + prod_sh;
            end
        end
    end

    // Datapath: registered ROM read, then MUL_LAT multiplier stages.
    always_ff @(posedge clk) begin
        s1_j  <= mj;
        s1_x  <= x_reg;
        s1_c  <= rom[rom_addr];
        pj[0] <= s1_j;
        pp[0] <= P_W'(s1_x) * P_W'(s1_c);
        for (int i = 1; i < int'(MUL_LAT); i++) begin
            pj[i] <= pj[i-1];
            pp[i] <= pp[i-1];
        end
    end

endmodule
